// File: rtl/uart_rx.sv
// 16x oversampling 8N1 UART receiver.
// Presents each received byte with a one-cycle done strobe.
module uart_rx #(
  parameter int N_DATA_BITS  = 8,
  parameter int N_TICKS      = 16,
  parameter int N_STOP_TICKS = 16
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_rx,
  input  logic                   i_tick,
  output logic [N_DATA_BITS-1:0] o_data,
  output logic                   o_rx_done,
  output logic                   o_frame_error
);

  localparam int MAX_T =
    (N_TICKS > N_STOP_TICKS) ? N_TICKS : N_STOP_TICKS;
  localparam int CW = (MAX_T > 1) ? $clog2(MAX_T) : 1;
  localparam int BW =
    (N_DATA_BITS > 1) ? $clog2(N_DATA_BITS) : 1;

  localparam logic [CW-1:0] T_MID  = CW'(N_TICKS / 2 - 1);
  localparam logic [CW-1:0] T_BIT  = CW'(N_TICKS - 1);
  localparam logic [CW-1:0] T_STOP = CW'(N_STOP_TICKS - 1);
  localparam logic [BW-1:0] B_LAST = BW'(N_DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t                 state;
  logic [CW-1:0]          tick_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [N_DATA_BITS-1:0] shreg;

  logic rx_meta;
  logic rx_s;
  logic rx_prev;
  logic [1:0] warm;
  logic armed;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // A line already low when reset releases must go high
  // before any falling edge counts; warm waits out the
  // synchronizer's reset value.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      warm  <= 2'b00;
      armed <= 1'b0;
    end else begin
      warm  <= {warm[0], 1'b1};
      armed <= armed | (warm[1] & rx_s);
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state         <= IDLE;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      o_data        <= '0;
      o_rx_done     <= 1'b0;
      o_frame_error <= 1'b0;
    end else begin
      o_rx_done     <= 1'b0;
      o_frame_error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (armed && rx_prev && !rx_s) begin
            state    <= START;
            tick_cnt <= '0;
          end
        end
        START: begin
          if (i_tick) begin
            if (tick_cnt == T_MID) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= rx_s ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (i_tick) begin
            if (tick_cnt == T_BIT) begin
              shreg <= {rx_s, shreg[N_DATA_BITS-1:1]};
              tick_cnt <= '0;
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == B_LAST) state <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (i_tick) begin
            if (tick_cnt == T_STOP) begin
              state    <= IDLE;
              tick_cnt <= '0;
              if (rx_s) begin
                o_data    <= shreg;
                o_rx_done <= 1'b1;
              end else begin
                o_frame_error <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx.
// Tick divider is shortened to keep runs small.
module tb_uart_rx;

  localparam int TICK_DIV = 10;
  localparam int BIT_CYC  = 16 * TICK_DIV;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       tick;
  logic [7:0] data;
  logic       done;
  logic       ferr;

  int vectors;
  int miscompares;
  int cyc;
  int tdiv;
  int done_cnt;
  int err_cnt;
  int wide_cnt;
  int both_cnt;
  int done_cyc;
  int start_cyc;
  logic done_q;
  logic ferr_q;

  uart_rx dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_rx         (rx),
    .i_tick       (tick),
    .o_data       (data),
    .o_rx_done    (done),
    .o_frame_error(ferr)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    tdiv = 0;
    tick = 1'b0;
    cyc  = 0;
  end

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    tdiv <= (tdiv == TICK_DIV - 1) ? 0 : tdiv + 1;
    tick <= (tdiv == TICK_DIV - 1);
  end

  initial begin
    done_cnt = 0;
    err_cnt  = 0;
    wide_cnt = 0;
    both_cnt = 0;
    done_cyc = 0;
    done_q   = 1'b0;
    ferr_q   = 1'b0;
  end

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
      if (done_q) wide_cnt = wide_cnt + 1;
    end
    if (ferr === 1'b1) begin
      err_cnt = err_cnt + 1;
      if (ferr_q) wide_cnt = wide_cnt + 1;
    end
    if (done === 1'b1 && ferr === 1'b1)
      both_cnt = both_cnt + 1;
    done_q = (done === 1'b1);
    ferr_q = (ferr === 1'b1);
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b,
                      input int per,
                      input logic stop);
    @(negedge clk);
    rx = 1'b0;
    start_cyc = cyc;
    repeat (per) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (per) @(negedge clk);
    end
    rx = stop;
    repeat (per) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int d0;
  int e0;
  int lat;

  initial begin
    vectors     = 0;
    miscompares = 0;
    start_cyc   = 0;
    rx  = 1'b1;
    rst = 1'b1;
    idle(5);
    check("rst_data", 32'(data), 32'h00);
    check("rst_done", 32'(done), 32'h0);
    check("rst_ferr", 32'(ferr), 32'h0);
    rst = 1'b0;
    idle(2 * BIT_CYC);

    send(8'h55, BIT_CYC, 1'b1);
    lat = done_cyc - start_cyc;
    check("d55_data", 32'(data), 32'h55);
    check("d55_cnt", 32'(done_cnt), 32'd1);
    check("d55_ferr", 32'(err_cnt), 32'd0);
    check("d55_lat",
          32'(lat >= 9 * BIT_CYC && lat <= 10 * BIT_CYC),
          32'd1);

    send(8'h00, BIT_CYC, 1'b1);
    check("b2b_00", 32'(data), 32'h00);
    send(8'hFF, BIT_CYC, 1'b1);
    check("b2b_ff", 32'(data), 32'hFF);
    send(8'hA3, BIT_CYC, 1'b1);
    check("b2b_a3", 32'(data), 32'hA3);
    check("b2b_cnt", 32'(done_cnt), 32'd4);
    idle(BIT_CYC);

    rx = 1'b0;
    idle(3 * TICK_DIV);
    rx = 1'b1;
    idle(3 * BIT_CYC);
    check("glitch_done", 32'(done_cnt), 32'd4);
    check("glitch_ferr", 32'(err_cnt), 32'd0);
    check("glitch_data", 32'(data), 32'hA3);
    send(8'h3C, BIT_CYC, 1'b1);
    check("d3c_data", 32'(data), 32'h3C);
    check("d3c_cnt", 32'(done_cnt), 32'd5);
    idle(BIT_CYC);

    send(8'h81, BIT_CYC, 1'b0);
    idle(30 * BIT_CYC);
    rx = 1'b1;
    idle(2 * BIT_CYC);
    check("brk_ferr", 32'(err_cnt), 32'd1);
    check("brk_done", 32'(done_cnt), 32'd5);
    check("brk_data", 32'(data), 32'h3C);

    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clk);
    rx = 1'b0;
    idle(BIT_CYC);
    rx = 1'b1;
    idle(3 * BIT_CYC);
    rx = 1'b0;
    idle(BIT_CYC / 2);
    #3 rst = 1'b1;
    #1;
    check("mrst_data", 32'(data), 32'h00);
    check("mrst_done", 32'(done), 32'h0);
    check("mrst_ferr", 32'(ferr), 32'h0);
    idle(10);
    rst = 1'b0;
    idle(12 * BIT_CYC);
    rx = 1'b1;
    idle(3 * BIT_CYC);
    check("mrst_dcnt", 32'(done_cnt - d0), 32'd0);
    check("mrst_ecnt", 32'(err_cnt - e0), 32'd0);
    send(8'h12, BIT_CYC, 1'b1);
    check("d12_data", 32'(data), 32'h12);
    idle(BIT_CYC);

    send(8'h96, BIT_CYC * 97 / 100, 1'b1);
    check("skew_lo", 32'(data), 32'h96);
    send(8'h00, BIT_CYC, 1'b1);
    check("skew_sep", 32'(data), 32'h00);
    send(8'h96, BIT_CYC * 103 / 100, 1'b1);
    check("skew_hi", 32'(data), 32'h96);
    check("skew_cnt", 32'(done_cnt - d0), 32'd4);
    idle(BIT_CYC);

    check("wide_pulse", 32'(wide_cnt), 32'd0);
    check("both_pulse", 32'(both_cnt), 32'd0);
    check("tot_ferr", 32'(err_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
